// File: rtl/cpu_defs.sv
// Shared constants for the 8-bit CPU controller: field widths, opcodes and
// instruction-cycle phases.
package cpu_defs;

  localparam int unsigned OPC_W = 3;
  localparam int unsigned PH_W  = 3;

  localparam logic [OPC_W-1:0] HLT = 3'd0;
  localparam logic [OPC_W-1:0] SKZ = 3'd1;
  localparam logic [OPC_W-1:0] ADD = 3'd2;
  localparam logic [OPC_W-1:0] AND = 3'd3;
  localparam logic [OPC_W-1:0] XOR = 3'd4;
  localparam logic [OPC_W-1:0] LDA = 3'd5;
  localparam logic [OPC_W-1:0] STO = 3'd6;
  localparam logic [OPC_W-1:0] JMP = 3'd7;

  localparam logic [PH_W-1:0] INST_ADDR  = 3'd0;
  localparam logic [PH_W-1:0] INST_FETCH = 3'd1;
  localparam logic [PH_W-1:0] INST_LOAD  = 3'd2;
  localparam logic [PH_W-1:0] IDLE       = 3'd3;
  localparam logic [PH_W-1:0] OP_ADDR    = 3'd4;
  localparam logic [PH_W-1:0] OP_FETCH   = 3'd5;
  localparam logic [PH_W-1:0] ALU_OP     = 3'd6;
  localparam logic [PH_W-1:0] STORE      = 3'd7;

  // Instructions that read a memory operand into the accumulator path.
  function automatic logic is_aluop(input logic [OPC_W-1:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Wrapping instruction-phase counter with count enable and async active-low reset.
module phase_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cpu_controller.sv
// Instruction sequencer: walks the 8-phase cycle and decodes datapath strobes
// combinationally from the current phase, opcode and zero flag.
module cpu_controller #(
  parameter int unsigned OPC_W = cpu_defs::OPC_W,
  parameter int unsigned PH_W  = cpu_defs::PH_W
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             ld_ac,
  output logic             ld_pc,
  output logic             inc_pc,
  output logic             data_e,
  output logic             wr,
  output logic             halt,
  output logic [PH_W-1:0]  phase
);

  import cpu_defs::*;

  logic halted_q, halted_d;
  logic enter_halt;
  logic aluop;

  assign aluop      = is_aluop(opcode);
  assign enter_halt = !halted_q && (phase == OP_ADDR) && (opcode == HLT);
  assign halted_d   = halted_q || enter_halt;

  // Counter freezes at OP_ADDR on the halting edge so phase reads 4 while halted.
  phase_counter #(
    .WIDTH (PH_W)
  ) u_phase_counter (
    .clk    (clk),
    .rst_   (rst_),
    .enable (!halted_q && !enter_halt),
    .count  (phase)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    data_e = 1'b0;
    wr     = 1'b0;
    halt   = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      unique case (phase)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = (opcode != HLT);
          halt   = (opcode == HLT);
        end
        OP_FETCH: begin
          rd = aluop;
        end
        ALU_OP: begin
          rd     = aluop;
          inc_pc = (opcode == SKZ) && zero;
          ld_pc  = (opcode == JMP);
          data_e = (opcode == STO);
        end
        STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = (opcode == JMP);
          inc_pc = (opcode == JMP);
          wr     = (opcode == STO);
          data_e = (opcode == STO);
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Randomized self-checking bench for cpu_controller against a phase/halt reference model.
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       rst_;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, ld_ac, ld_pc, inc_pc, data_e, wr, halt;
  logic [2:0] phase;

  int total = 0;
  int bad   = 0;

  // Reference model state: instruction phase and halted flag.
  int m_ph   = 0;
  bit m_halt = 1'b0;

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk    (clk),
    .rst_   (rst_),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .ld_ac  (ld_ac),
    .ld_pc  (ld_pc),
    .inc_pc (inc_pc),
    .data_e (data_e),
    .wr     (wr),
    .halt   (halt),
    .phase  (phase)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected strobes {sel,rd,ld_ir,ld_ac,ld_pc,inc_pc,data_e,wr,halt}.
  function automatic logic [8:0] ref_out(input int ph, input bit h, input int op, input bit z);
    bit alu, e_sel, e_rd, e_ir, e_ac, e_ldpc, e_inc, e_de, e_wr, e_halt;
    alu    = (op >= 2) && (op <= 5);
    e_sel  = !h && (ph <= 3);
    e_rd   = !h && ((ph >= 1 && ph <= 3) || (ph >= 5 && alu));
    e_ir   = !h && (ph == 2 || ph == 3);
    e_ac   = !h && (ph == 7) && alu;
    e_ldpc = !h && (ph >= 6) && (op == 7);
    e_inc  = !h && ((ph == 4 && op != 0) || (ph == 6 && op == 1 && z) || (ph == 7 && op == 7));
    e_de   = !h && (ph >= 6) && (op == 6);
    e_wr   = !h && (ph == 7) && (op == 6);
    e_halt = h || (ph == 4 && op == 0);
    return {e_sel, e_rd, e_ir, e_ac, e_ldpc, e_inc, e_de, e_wr, e_halt};
  endfunction

  task automatic check_now(input string tag);
    int exp_ph;
    exp_ph = m_halt ? 4 : m_ph;
    check($sformatf("%s ph%0d op%0d outs", tag, exp_ph, opcode),
          32'({sel, rd, ld_ir, ld_ac, ld_pc, inc_pc, data_e, wr, halt}),
          32'(ref_out(exp_ph, m_halt, int'(opcode), zero)));
    check($sformatf("%s phase", tag), 32'(phase), 32'(exp_ph));
  endtask

  // One clock: drive inputs, check mid-cycle, then advance the model on the edge.
  task automatic step(input string tag, input logic [2:0] op, input logic z);
    @(negedge clk);
    opcode = op;
    zero   = z;
    #1;
    check_now(tag);
    @(posedge clk);
    #1;
    if (!rst_) begin
      m_ph   = 0;
      m_halt = 1'b0;
    end else if (!m_halt) begin
      if (m_ph == 4 && op == 3'd0) m_halt = 1'b1;
      else m_ph = (m_ph + 1) % 8;
    end
  endtask

  // Runs n phases of one instruction; opcode is don't-care before phase 4.
  task automatic run_instr(input string tag, input logic [2:0] op, input int zmode, input int n);
    logic [2:0] drv;
    logic       z;
    for (int i = 0; i < n; i++) begin
      drv = (m_ph < 4 && !m_halt) ? 3'($urandom) : op;
      z   = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      step(tag, drv, z);
    end
  endtask

  // Asynchronous reset asserted between edges, held one edge, then released.
  task automatic reset_pulse(input string tag);
    #2;
    rst_   = 1'b0;
    m_ph   = 0;
    m_halt = 1'b0;
    #1;
    check_now({tag, " async"});
    step({tag, " held"}, 3'($urandom), 1'($urandom));
    #1;
    rst_ = 1'b1;
  endtask

  initial begin
    rst_   = 1'b0;
    opcode = 3'd5;
    zero   = 1'b0;
    for (int i = 0; i < 3; i++) step("reset", 3'd5, 1'b0);
    #1;
    rst_ = 1'b1;

    run_instr("lda", 3'd5, 2, 8);
    run_instr("sto", 3'd6, 2, 8);
    run_instr("skz_z1", 3'd1, 1, 8);
    run_instr("skz_z0", 3'd1, 0, 8);
    run_instr("jmp", 3'd7, 2, 8);

    // Abort a store just before its write phase.
    run_instr("sto_abort", 3'd6, 2, 7);
    reset_pulse("sto_abort rst");

    for (int k = 0; k < 40; k++) begin
      run_instr("rand", 3'($urandom_range(7, 1)), 2, 8);
    end

    run_instr("hlt", 3'd0, 2, 8);
    for (int i = 0; i < 20; i++) step("halted", 3'($urandom), 1'($urandom));
    reset_pulse("hlt rst");
    run_instr("post_hlt", 3'd2, 2, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
